execute_cond_stage: RTL and testbench
=====================================

Name: execute_cond_stage

Overview:
Execute-stage control block, directly downstream of the decode-stage control unit. It registers the decoded control bundle into the E stage, with stall and flush support, and holds the architectural NZCV flags register. It evaluates the instruction's 4-bit condition field against the held flags and gates every architectural side effect (register write, memory write, PC write, branch) with the condition result. Its gated outputs feed the E/M pipeline register and the hazard/fetch logic.

Parameters:
WIDTH, 8, datapath width; carried for interface uniformity, no control logic depends on it
COND_AL, 4'b1110, condition code treated as "always"

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
StallE  input  1  hold E-stage register and flags
FlushE  input  1  load a bubble into the E-stage register
PCSrcD  input  1  decode: instruction writes PC
RegWriteD  input  1  decode: register write
MemToRegD  input  1  decode: writeback selects memory data
MemWriteD  input  1  decode: memory write
BranchD  input  1  decode: branch
ALUSrcD  input  1  decode: ALU operand B is the immediate
NoWriteD  input  1  decode: compare-type, suppress register write
ALUControlD  input  4  decode: ALU operation
FlagWriteD  input  2  [1] updates N,Z; [0] updates C,V
CondD  input  4  instruction condition field
ALUFlags  input  4  {N,Z,C,V} from the E-stage ALU, same cycle
ALUControlE  output  4  registered ALU operation
ALUSrcE  output  1  registered
MemToRegE  output  1  registered
RegWriteGatedE  output  1  RegWriteE & CondExE & ~NoWriteE
MemWriteGatedE  output  1  MemWriteE & CondExE
PCSrcGatedE  output  1  PCSrcE & CondExE
BranchTakenE  output  1  BranchE & CondExE
CondExE  output  1  condition passed
FlagsE  output  4  current flags register {N,Z,C,V}

Behaviour:
- Reset (asynchronous, while high):
  - All E-stage control registers are 0 and CondE = COND_AL.
  - FlagsE = 4'b0000.
  - All gated outputs are therefore 0.
- E-stage register update, at the rising edge, priority FlushE > StallE > capture:
  - FlushE: bubble, meaning all enables 0, ALUControlE = 0, CondE = COND_AL.
  - StallE only: hold all contents.
  - Otherwise: capture all D inputs.
- Latency: control captured at edge k is visible on the E outputs during cycle k+1.
- Condition check is combinational on CondE and the registered FlagsE, never on ALUFlags:
  - EQ 0000: Z; NE 0001: ~Z
  - CS 0010: C; CC 0011: ~C
  - MI 0100: N; PL 0101: ~N
  - VS 0110: V; VC 0111: ~V
  - HI 1000: C & ~Z; LS 1001: ~C | Z
  - GE 1010: N == V; LT 1011: N != V
  - GT 1100: ~Z & (N == V); LE 1101: Z | (N != V)
  - AL 1110: 1
  - 1111: 0 (reserved, never executes)
- Flags register update, at the rising edge when ~StallE and CondExE:
  - FlagWriteE[1] loads N,Z from ALUFlags[3:2].
  - FlagWriteE[0] loads C,V from ALUFlags[1:0].
  - Otherwise the flags hold.
- The instruction currently in E completes its flag update even when FlushE is high in the same cycle; the flush affects only the incoming instruction.
- A failed condition blocks flag writes as well as register, memory and PC writes.
- Back-to-back dependency: a compare in E at cycle k sets flags at edge k+1; a conditional branch entering E in cycle k+1 sees the new flags. No forwarding path and no extra stall are needed.
- Reset asserted mid-operation: the pipeline register and flags clear immediately, and outputs go to 0 without waiting for a clock edge.
- NoWriteE suppresses only the register write. Flag writes still follow FlagWriteE.

Decomposition:
- Shared package:
  - cond_e enum holding the 16 condition codes.
  - flags_t packed struct {n, z, c, v}.
  - ctrl_e_t packed struct holding the registered control bundle.
  - Bubble constant CTRL_BUBBLE.
- One combinational sub-module, cond_check: inputs cond (4) and flags_t; output cond_ex.
- The pipeline register and flags register live in execute_cond_stage.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0, FlagsE = 0000, CondExE = 1 (AL), asynchronously.
- Flag set and conditional branch:
  - Stimulus: compare with NoWriteD = 1, RegWriteD = 1, FlagWriteD = 11, ALUFlags = 0100, CondD = AL; next instruction BranchD = 1, CondD = EQ.
  - Required: FlagsE = 0100 and BranchTakenE = 1 in the branch's E cycle; RegWriteGatedE = 0 for the compare.
- Failed condition:
  - Stimulus: FlagsE = 0000, instruction RegWriteD = 1, MemWriteD = 1, FlagWriteD = 11, CondD = EQ, ALUFlags = 1111.
  - Required: all gated outputs 0; FlagsE stays 0000.
- Flush versus stall priority:
  - Stimulus: FlushE = 1 and StallE = 1 with RegWriteD = 1.
  - Required: next cycle RegWriteGatedE = 0 and ALUControlE = 0000.
  - Stimulus: StallE = 1 alone for 3 cycles.
  - Required: outputs frozen; flags unchanged even with FlagWriteE = 11.
- Signed compares:
  - Stimulus: flags N = 1, V = 0.
  - Required: GE -> CondExE = 0, LT -> 1, GT -> 0, LE -> 1.
  - Stimulus: flags N = 1, V = 1, Z = 0.
  - Required: GT -> 1.
- Partial flag write and reserved code:
  - Stimulus: FlagWriteD = 01 with ALUFlags = 1111 from FlagsE = 0000.
  - Required: FlagsE = 0011.
  - Stimulus: CondD = 1111.
  - Required: CondExE = 0.

Source files
------------

// File: rtl/execute_cond_stage_pkg.sv
// execute_cond_stage_pkg
// Shared types for the execute-stage control slice:
//   cond_e      - the 16 instruction condition codes
//   flags_t     - architectural flags {n, z, c, v}
//   ctrl_e_t    - decoded control bundle held in the E-stage register
//   CTRL_BUBBLE - bubble contents: every enable low, condition "always"
package execute_cond_stage_pkg;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000,
    C_NE = 4'b0001,
    C_CS = 4'b0010,
    C_CC = 4'b0011,
    C_MI = 4'b0100,
    C_PL = 4'b0101,
    C_VS = 4'b0110,
    C_VC = 4'b0111,
    C_HI = 4'b1000,
    C_LS = 4'b1001,
    C_GE = 4'b1010,
    C_LT = 4'b1011,
    C_GT = 4'b1100,
    C_LE = 4'b1101,
    C_AL = 4'b1110,
    C_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic       pcSrc;
    logic       regWrite;
    logic       memToReg;
    logic       memWrite;
    logic       branch;
    logic       aluSrc;
    logic       noWrite;
    logic [3:0] aluControl;
    logic [1:0] flagWrite;
    cond_e      cond;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_BUBBLE = '{
    pcSrc:      1'b0,
    regWrite:   1'b0,
    memToReg:   1'b0,
    memWrite:   1'b0,
    branch:     1'b0,
    aluSrc:     1'b0,
    noWrite:    1'b0,
    aluControl: 4'b0000,
    flagWrite:  2'b00,
    cond:       C_AL
  };

endpackage

// File: rtl/execute_cond_stage_cond_check.sv
// cond_check
// Purely combinational evaluation of a 4-bit condition field against the
// held architectural flags.
//   cond    (in, 4)  condition field of the instruction in E
//   flags   (in)     flags register contents {n, z, c, v}
//   cond_ex (out, 1) high when the instruction is allowed to execute
module cond_check
  import execute_cond_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_ex
);

  // Code 1111 is reserved and deliberately never executes.
  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      C_EQ: cond_ex = flags.z;
      C_NE: cond_ex = ~flags.z;
      C_CS: cond_ex = flags.c;
      C_CC: cond_ex = ~flags.c;
      C_MI: cond_ex = flags.n;
      C_PL: cond_ex = ~flags.n;
      C_VS: cond_ex = flags.v;
      C_VC: cond_ex = ~flags.v;
      C_HI: cond_ex = flags.c & ~flags.z;
      C_LS: cond_ex = ~flags.c | flags.z;
      C_GE: cond_ex = (flags.n == flags.v);
      C_LT: cond_ex = (flags.n != flags.v);
      C_GT: cond_ex = ~flags.z & (flags.n == flags.v);
      C_LE: cond_ex = flags.z | (flags.n != flags.v);
      C_AL: cond_ex = 1'b1;
      C_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cond_stage.sv
// execute_cond_stage
// E-stage control register plus the NZCV flags register. The decoded control
// bundle is registered (flush beats stall beats capture), its condition field
// is checked against the held flags, and every architectural side effect is
// gated by that result.
//   clk, reset            clock and asynchronous active-high reset
//   StallE, FlushE        hold / bubble the E-stage register
//   *D inputs             decoded control bundle and condition field
//   ALUFlags              {N,Z,C,V} from the E-stage ALU this cycle
//   ALUControlE, ALUSrcE, MemToRegE   registered controls
//   *GatedE, BranchTakenE side effects gated by CondExE
//   CondExE, FlagsE       condition result and current flags
module execute_cond_stage
  import execute_cond_stage_pkg::*;
#(
  parameter int         WIDTH   = 8,
  parameter logic [3:0] COND_AL = 4'b1110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemToRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic       NoWriteD,
  input  logic [3:0] ALUControlD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlags,
  output logic [3:0] ALUControlE,
  output logic       ALUSrcE,
  output logic       MemToRegE,
  output logic       RegWriteGatedE,
  output logic       MemWriteGatedE,
  output logic       PCSrcGatedE,
  output logic       BranchTakenE,
  output logic       CondExE,
  output logic [3:0] FlagsE
);

  // The datapath width is carried only so every stage shares one interface.
  if (WIDTH < 1) begin : gWidthCheck
    $error("execute_cond_stage: WIDTH must be at least 1");
  end

  // Bubble whose "always" code follows the COND_AL parameter.
  localparam ctrl_e_t BubbleCtrl = '{
    pcSrc:      1'b0,
    regWrite:   1'b0,
    memToReg:   1'b0,
    memWrite:   1'b0,
    branch:     1'b0,
    aluSrc:     1'b0,
    noWrite:    1'b0,
    aluControl: 4'b0000,
    flagWrite:  2'b00,
    cond:       cond_e'(COND_AL)
  };

  ctrl_e_t ctrl_q, ctrl_d;
  flags_t  flags_q, flags_d;
  logic    condEx;

  // Flush wins over stall so a squashed instruction can never be held in E.
  always_comb begin
    ctrl_d = ctrl_q;
    if (FlushE) begin
      ctrl_d = BubbleCtrl;
    end else if (!StallE) begin
      ctrl_d = '{
        pcSrc:      PCSrcD,
        regWrite:   RegWriteD,
        memToReg:   MemToRegD,
        memWrite:   MemWriteD,
        branch:     BranchD,
        aluSrc:     ALUSrcD,
        noWrite:    NoWriteD,
        aluControl: ALUControlD,
        flagWrite:  FlagWriteD,
        cond:       cond_e'(CondD)
      };
    end
  end

  // The instruction already in E still commits its flags when FlushE is high;
  // only a stall or a failed condition blocks the update.
  always_comb begin
    flags_d = flags_q;
    if (!StallE && condEx) begin
      if (ctrl_q.flagWrite[1]) begin
        flags_d.n = ALUFlags[3];
        flags_d.z = ALUFlags[2];
      end
      if (ctrl_q.flagWrite[0]) begin
        flags_d.c = ALUFlags[1];
        flags_d.v = ALUFlags[0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= BubbleCtrl;
      flags_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      flags_q <= flags_d;
    end
  end

  // Checked against registered flags so a compare in E one cycle earlier is
  // visible to a dependent branch with no forwarding.
  cond_check uCondCheck (
    .cond    (ctrl_q.cond),
    .flags   (flags_q),
    .cond_ex (condEx)
  );

  assign ALUControlE    = ctrl_q.aluControl;
  assign ALUSrcE        = ctrl_q.aluSrc;
  assign MemToRegE      = ctrl_q.memToReg;
  assign RegWriteGatedE = ctrl_q.regWrite & condEx & ~ctrl_q.noWrite;
  assign MemWriteGatedE = ctrl_q.memWrite & condEx;
  assign PCSrcGatedE    = ctrl_q.pcSrc & condEx;
  assign BranchTakenE   = ctrl_q.branch & condEx;
  assign CondExE        = condEx;
  assign FlagsE         = flags_q;

endmodule

// File: tb/tb_execute_cond_stage.sv
// tb_execute_cond_stage
// Directed bench for execute_cond_stage. Each step drives the next decode
// bundle plus the ALU flags of the instruction currently in E, pushes what the
// E outputs must show after the edge, and pops/compares one cycle later.
module tb_execute_cond_stage;
  import execute_cond_stage_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       StallE, FlushE;
  logic       PCSrcD, RegWriteD, MemToRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD;
  logic [3:0] ALUControlD;
  logic [1:0] FlagWriteD;
  logic [3:0] CondD;
  logic [3:0] ALUFlags;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, MemToRegE, RegWriteGatedE, MemWriteGatedE;
  logic       PCSrcGatedE, BranchTakenE, CondExE;
  logic [3:0] FlagsE;

  typedef struct {
    string      tag;
    logic [3:0] aluCtl;
    logic       aluSrc;
    logic       memToReg;
    logic       regWG;
    logic       memWG;
    logic       pcSG;
    logic       brT;
    logic       condEx;
    logic [3:0] flags;
  } exp_t;

  exp_t sb[$];
  int   nAsserts = 0;
  int   nFails   = 0;

  execute_cond_stage #(.WIDTH(8), .COND_AL(4'b1110)) dut (
    .clk            (clk),
    .reset          (reset),
    .StallE         (StallE),
    .FlushE         (FlushE),
    .PCSrcD         (PCSrcD),
    .RegWriteD      (RegWriteD),
    .MemToRegD      (MemToRegD),
    .MemWriteD      (MemWriteD),
    .BranchD        (BranchD),
    .ALUSrcD        (ALUSrcD),
    .NoWriteD       (NoWriteD),
    .ALUControlD    (ALUControlD),
    .FlagWriteD     (FlagWriteD),
    .CondD          (CondD),
    .ALUFlags       (ALUFlags),
    .ALUControlE    (ALUControlE),
    .ALUSrcE        (ALUSrcE),
    .MemToRegE      (MemToRegE),
    .RegWriteGatedE (RegWriteGatedE),
    .MemWriteGatedE (MemWriteGatedE),
    .PCSrcGatedE    (PCSrcGatedE),
    .BranchTakenE   (BranchTakenE),
    .CondExE        (CondExE),
    .FlagsE         (FlagsE)
  );

  always #5 clk = ~clk;

  function automatic ctrl_e_t mk(input logic pcSrc, input logic regW,
                                 input logic memToReg, input logic memW,
                                 input logic br, input logic aluSrc,
                                 input logic noW, input logic [3:0] alu,
                                 input logic [1:0] fw, input logic [3:0] cond);
    ctrl_e_t c;
    c.pcSrc      = pcSrc;
    c.regWrite   = regW;
    c.memToReg   = memToReg;
    c.memWrite   = memW;
    c.branch     = br;
    c.aluSrc     = aluSrc;
    c.noWrite    = noW;
    c.aluControl = alu;
    c.flagWrite  = fw;
    c.cond       = cond_e'(cond);
    return c;
  endfunction

  task automatic applyStimulus(input ctrl_e_t c, input logic [3:0] aluFl,
                               input logic stall, input logic flush);
    PCSrcD      = c.pcSrc;
    RegWriteD   = c.regWrite;
    MemToRegD   = c.memToReg;
    MemWriteD   = c.memWrite;
    BranchD     = c.branch;
    ALUSrcD     = c.aluSrc;
    NoWriteD    = c.noWrite;
    ALUControlD = c.aluControl;
    FlagWriteD  = c.flagWrite;
    CondD       = c.cond;
    ALUFlags    = aluFl;
    StallE      = stall;
    FlushE      = flush;
  endtask

  task automatic expectE(input string tag, input logic [3:0] aluCtl,
                         input logic aluSrc, input logic memToReg,
                         input logic regWG, input logic memWG, input logic pcSG,
                         input logic brT, input logic condEx,
                         input logic [3:0] flags);
    exp_t e;
    e.tag = tag; e.aluCtl = aluCtl; e.aluSrc = aluSrc; e.memToReg = memToReg;
    e.regWG = regWG; e.memWG = memWG; e.pcSG = pcSG; e.brT = brT;
    e.condEx = condEx; e.flags = flags;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] obs, input logic [3:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    nAsserts++;
    assert (sb.size() > 0)
    else begin
      nFails++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "/ALUControlE"},    ALUControlE,           e.aluCtl);
    chk({e.tag, "/ALUSrcE"},        {3'b0, ALUSrcE},        {3'b0, e.aluSrc});
    chk({e.tag, "/MemToRegE"},      {3'b0, MemToRegE},      {3'b0, e.memToReg});
    chk({e.tag, "/RegWriteGatedE"}, {3'b0, RegWriteGatedE}, {3'b0, e.regWG});
    chk({e.tag, "/MemWriteGatedE"}, {3'b0, MemWriteGatedE}, {3'b0, e.memWG});
    chk({e.tag, "/PCSrcGatedE"},    {3'b0, PCSrcGatedE},    {3'b0, e.pcSG});
    chk({e.tag, "/BranchTakenE"},   {3'b0, BranchTakenE},   {3'b0, e.brT});
    chk({e.tag, "/CondExE"},        {3'b0, CondExE},        {3'b0, e.condEx});
    chk({e.tag, "/FlagsE"},         FlagsE,                 e.flags);
  endtask

  task automatic stepCheck();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(mk(0,0,0,0,0,0,0,4'h0,2'b00,4'b1110), 4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expectE("reset", 4'h0, 0,0,0,0,0,0, 1, 4'b0000);
    checkOutput();
    reset = 1'b0;

    // Compare: sets flags, register write suppressed by NoWrite.
    applyStimulus(mk(0,1,0,0,0,1,1,4'hA,2'b11,4'b1110), 4'b0000, 0, 0);
    expectE("cmp", 4'hA, 1,0,0,0,0,0, 1, 4'b0000);
    stepCheck();
    // BEQ right behind it sees Z from the compare.
    applyStimulus(mk(0,0,0,0,1,0,0,4'h0,2'b00,4'b0000), 4'b0100, 0, 0);
    expectE("beq", 4'h0, 0,0,0,0,0,1, 1, 4'b0100);
    stepCheck();

    // Clear flags, then an EQ instruction that must fail completely.
    applyStimulus(mk(0,1,0,0,0,0,0,4'h1,2'b11,4'b1110), 4'b0000, 0, 0);
    expectE("clr", 4'h1, 0,0,1,0,0,0, 1, 4'b0100);
    stepCheck();
    applyStimulus(mk(0,1,0,1,0,0,0,4'h2,2'b11,4'b0000), 4'b0000, 0, 0);
    expectE("failEq", 4'h2, 0,0,0,0,0,0, 0, 4'b0000);
    stepCheck();
    applyStimulus(mk(0,0,0,0,0,0,0,4'h0,2'b00,4'b1110), 4'b1111, 0, 0);
    expectE("afterFail", 4'h0, 0,0,0,0,0,0, 1, 4'b0000);
    stepCheck();

    // Flush and stall together: flush wins.
    applyStimulus(mk(0,1,0,0,0,0,0,4'h7,2'b00,4'b1110), 4'b0000, 1, 1);
    expectE("flushStall", 4'h0, 0,0,0,0,0,0, 1, 4'b0000);
    stepCheck();

    // Flush still lets the instruction in E commit its flags.
    applyStimulus(mk(0,1,1,0,0,0,0,4'h3,2'b11,4'b1110), 4'b0000, 0, 0);
    expectE("preFlush", 4'h3, 0,1,1,0,0,0, 1, 4'b0000);
    stepCheck();
    applyStimulus(mk(1,0,0,1,0,0,0,4'h9,2'b00,4'b1110), 4'b1000, 0, 1);
    expectE("flushFlags", 4'h0, 0,0,0,0,0,0, 1, 4'b1000);
    stepCheck();

    // Stall for three cycles with a flag-writing instruction held in E.
    applyStimulus(mk(1,0,0,1,0,1,0,4'h5,2'b11,4'b1110), 4'b0000, 0, 0);
    expectE("preStall", 4'h5, 1,0,0,1,1,0, 1, 4'b1000);
    stepCheck();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(0,1,0,0,0,0,0,4'hF,2'b00,4'b0000), 4'b0110, 1, 0);
      expectE("stall", 4'h5, 1,0,0,1,1,0, 1, 4'b1000);
      stepCheck();
    end

    // Signed conditions with N=1, V=0.
    applyStimulus(mk(0,0,0,0,1,0,0,4'h0,2'b00,4'b1010), 4'b1000, 0, 0);
    expectE("ge", 4'h0, 0,0,0,0,0,0, 0, 4'b1000);
    stepCheck();
    applyStimulus(mk(0,0,0,0,1,0,0,4'h0,2'b00,4'b1011), 4'b0000, 0, 0);
    expectE("lt", 4'h0, 0,0,0,0,0,1, 1, 4'b1000);
    stepCheck();
    applyStimulus(mk(0,0,0,0,1,0,0,4'h0,2'b00,4'b1100), 4'b0000, 0, 0);
    expectE("gt", 4'h0, 0,0,0,0,0,0, 0, 4'b1000);
    stepCheck();
    applyStimulus(mk(0,0,0,0,1,0,0,4'h0,2'b00,4'b1101), 4'b0000, 0, 0);
    expectE("le", 4'h0, 0,0,0,0,0,1, 1, 4'b1000);
    stepCheck();

    // Set N=1, V=1, Z=0 and check GT passes.
    applyStimulus(mk(0,0,0,0,0,0,0,4'h4,2'b11,4'b1110), 4'b0000, 0, 0);
    expectE("setNV", 4'h4, 0,0,0,0,0,0, 1, 4'b1000);
    stepCheck();
    applyStimulus(mk(0,0,0,0,1,0,0,4'h0,2'b00,4'b1100), 4'b1001, 0, 0);
    expectE("gtNV", 4'h0, 0,0,0,0,0,1, 1, 4'b1001);
    stepCheck();

    // Partial flag write (C,V only) from cleared flags.
    applyStimulus(mk(0,0,0,0,0,0,0,4'h6,2'b11,4'b1110), 4'b0000, 0, 0);
    expectE("clr2", 4'h6, 0,0,0,0,0,0, 1, 4'b1001);
    stepCheck();
    applyStimulus(mk(0,1,0,0,0,0,0,4'h8,2'b01,4'b1110), 4'b0000, 0, 0);
    expectE("partial", 4'h8, 0,0,1,0,0,0, 1, 4'b0000);
    stepCheck();

    // Reserved condition never executes, including its flag write.
    applyStimulus(mk(1,1,0,1,1,0,0,4'hB,2'b11,4'b1111), 4'b1111, 0, 0);
    expectE("reserved", 4'hB, 0,0,0,0,0,0, 0, 4'b0011);
    stepCheck();
    applyStimulus(mk(0,0,0,0,0,0,0,4'h0,2'b00,4'b1110), 4'b1111, 0, 0);
    expectE("afterRsv", 4'h0, 0,0,0,0,0,0, 1, 4'b0011);
    stepCheck();

    // MI fails and HI passes with flags 0011.
    applyStimulus(mk(0,0,0,0,1,0,0,4'h0,2'b00,4'b0100), 4'b0000, 0, 0);
    expectE("mi", 4'h0, 0,0,0,0,0,0, 0, 4'b0011);
    stepCheck();
    applyStimulus(mk(0,0,0,0,1,0,0,4'h0,2'b00,4'b1000), 4'b0000, 0, 0);
    expectE("hi", 4'h0, 0,0,0,0,0,1, 1, 4'b0011);
    stepCheck();

    // Reset in the middle of a cycle clears everything without an edge.
    #2;
    reset = 1'b1;
    #1;
    expectE("asyncReset", 4'h0, 0,0,0,0,0,0, 1, 4'b0000);
    checkOutput();
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
